// File: rtl/disp_src_arbiter_pkg.sv
// disp_pkg: shared constants and helpers for the display source arbiter.
package disp_pkg;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SHOW = 1'b1;
  localparam int DWELL_DEFAULT = 50_000_000;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/disp_src_arbiter_if.sv
// disp_src_arbiter_if: requester taps in, display driver controls out.
interface disp_src_arbiter_if import disp_pkg::*; #(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 32
);
  localparam int SW = idx_w(NUM_SRC);
  logic [NUM_SRC-1:0]            src_valid;
  logic [NUM_SRC*DATA_WIDTH-1:0] src_data;
  logic                          lock;
  logic [NUM_SRC-1:0]            src_ack;
  logic [DATA_WIDTH-1:0]         disp_value;
  logic [SW-1:0]                 disp_src;
  logic                          disp_blank;
  modport master (input src_valid, src_data, lock, output src_ack, disp_value, disp_src, disp_blank);
  modport slave  (output src_valid, src_data, lock, input src_ack, disp_value, disp_src, disp_blank);
endinterface

// File: rtl/disp_src_arbiter_rr_pick.sv
// rr_pick: first request after last_i with wrap-around, optionally skipping one index.
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] last_i,
  input  logic         mask_en_i,
  input  logic [W-1:0] mask_idx_i,
  output logic [W-1:0] idx_o,
  output logic         any_o
);
  logic [W-1:0] k;
  // Scan farthest offset first so the nearest candidate after last_i wins.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    k     = '0;
    for (int i = N; i >= 1; i--) begin
      k = W'((int'(last_i) + i) % N);
      if (req_i[k] && !(mask_en_i && k == mask_idx_i)) begin
        idx_o = k;
        any_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/disp_src_arbiter.sv
// disp_src_arbiter: round-robin time-multiplexing of debug sources onto one display.
module disp_src_arbiter import disp_pkg::*; #(
  parameter int NUM_SRC      = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int DWELL_CYCLES = DWELL_DEFAULT
) (
  input logic clk,
  input logic rst,
  disp_src_arbiter_if.master bus
);
  localparam int SW = idx_w(NUM_SRC);
  localparam int CW = $clog2(DWELL_CYCLES);
  logic [0:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [SW-1:0]         rr_q, rr_d, src_q, src_d, pick;
  logic [DATA_WIDTH-1:0] val_q, val_d, cur_data, pick_data;
  logic [NUM_SRC-1:0]    ack_q, ack_d;
  logic                  blank_q, blank_d, zero_q, zero_d;
  logic                  any, none, grant, drop, show;
  rr_pick #(.N(NUM_SRC), .W(SW)) u_pick (
    .req_i(bus.src_valid), .last_i(rr_q), .mask_en_i(show), .mask_idx_i(src_q),
    .idx_o(pick), .any_o(any)
  );
  assign show      = state_q == ST_SHOW;
  assign none      = bus.src_valid == '0;
  assign cur_data  = bus.src_data[int'(src_q)*DATA_WIDTH +: DATA_WIDTH];
  assign pick_data = bus.src_data[int'(pick)*DATA_WIDTH +: DATA_WIDTH];
  assign grant     = show ? (cnt_q == '0 && !bus.lock && any) : any;
  // Leave SHOW on an empty expiry, or after two consecutive empty unlocked cycles.
  assign drop      = show && none && !bus.lock && (cnt_q == '0 || zero_q);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    src_d   = src_q;
    val_d   = val_q;
    blank_d = blank_q;
    ack_d   = '0;
    zero_d  = 1'b0;
    if (grant) begin
      state_d = ST_SHOW;
      cnt_d   = CW'(DWELL_CYCLES - 1);
      rr_d    = pick;
      src_d   = pick;
      val_d   = pick_data;
      blank_d = 1'b0;
      ack_d   = NUM_SRC'(1) << pick;
    end else if (drop) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      val_d   = '0;
      blank_d = 1'b1;
    end else if (show) begin
      val_d  = bus.src_valid[src_q] ? cur_data : val_q;
      cnt_d  = (cnt_q == '0) ? CW'(DWELL_CYCLES - 1) : cnt_q - 1'b1;
      zero_d = none && !bus.lock;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rr_q    <= SW'(NUM_SRC - 1);
      src_q   <= '0;
      val_q   <= '0;
      blank_q <= 1'b1;
      ack_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      src_q   <= src_d;
      val_q   <= val_d;
      blank_q <= blank_d;
      ack_q   <= ack_d;
      zero_q  <= zero_d;
    end
  end
  assign bus.src_ack    = ack_q;
  assign bus.disp_value = val_q;
  assign bus.disp_src   = src_q;
  assign bus.disp_blank = blank_q;
endmodule

// File: tb/tb_disp_src_arbiter.sv
// tb_disp_src_arbiter: scenario tasks with a grant scoreboard for disp_src_arbiter.
module tb_disp_src_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  disp_src_arbiter_if #(.NUM_SRC(4), .DATA_WIDTH(32)) bif();
  disp_src_arbiter #(.NUM_SRC(4), .DATA_WIDTH(32), .DWELL_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .bus(bif)
  );
  typedef struct packed {
    logic [3:0]  ack;
    logic [1:0]  src;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];
  int tests = 0;
  int fails = 0;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic set_data(input int i, input logic [31:0] v);
    bif.src_data[i*32 +: 32] = v;
  endtask
  task automatic push(input logic [3:0] a, input logic [1:0] s, input logic [31:0] v);
    exp_t e;
    e.ack = a;
    e.src = s;
    e.val = v;
    sb.push_back(e);
  endtask
  task automatic wait_grant(input int budget, output int n);
    exp_t e;
    n = 0;
    do begin
      step();
      n++;
    end while (bif.src_ack == 4'b0 && n < budget);
    tests++;
    if (bif.src_ack == 4'b0) begin
      fails++;
      $display("FAIL grant_timeout: no src_ack within %0d cycles", budget);
    end else if (sb.size() == 0) begin
      fails++;
      $display("FAIL unexpected_grant: got ack=%b with nothing expected", bif.src_ack);
    end else begin
      e = sb.pop_front();
      if (bif.src_ack !== e.ack || bif.disp_src !== e.src || bif.disp_value !== e.val || bif.disp_blank !== 1'b0) begin
        fails++;
        $display("FAIL grant: got ack=%b src=%0d val=%h blank=%b, expected ack=%b src=%0d val=%h blank=0",
                 bif.src_ack, bif.disp_src, bif.disp_value, bif.disp_blank, e.ack, e.src, e.val);
      end
    end
  endtask
  task automatic go_idle(input string tag);
    bif.src_valid = 4'b0;
    bif.lock = 1'b0;
    repeat (3) step();
    tests++;
    if (bif.disp_blank !== 1'b1 || bif.disp_value !== 32'h0) begin
      fails++;
      $display("FAIL %s: got blank=%b val=%h, expected blank=1 val=0", tag, bif.disp_blank, bif.disp_value);
    end
  endtask
  task automatic test_reset();
    rst = 1'b0;
    bif.src_valid = 4'b0;
    bif.src_data = '0;
    bif.lock = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      tests++;
      if (bif.disp_blank !== 1'b1 || bif.disp_value !== 32'h0 || bif.src_ack !== 4'b0) begin
        fails++;
        $display("FAIL reset_idle cycle %0d: got blank=%b val=%h ack=%b, expected 1/0/0",
                 i, bif.disp_blank, bif.disp_value, bif.src_ack);
      end
    end
  endtask
  task automatic test_alternate();
    int n;
    set_data(0, 32'h1111_1111);
    set_data(2, 32'h2222_2222);
    bif.src_valid = 4'b0101;
    push(4'b0001, 2'd0, 32'h1111_1111);
    push(4'b0100, 2'd2, 32'h2222_2222);
    push(4'b0001, 2'd0, 32'h1111_1111);
    push(4'b0100, 2'd2, 32'h2222_2222);
    wait_grant(3, n);
    tests++;
    if (n !== 1) begin
      fails++;
      $display("FAIL grant_latency: got %0d cycles, expected 1", n);
    end
    for (int k = 0; k < 3; k++) begin
      wait_grant(10, n);
      tests++;
      if (n !== 8) begin
        fails++;
        $display("FAIL dwell_%0d: got %0d cycles between grants, expected 8", k, n);
      end
    end
    go_idle("idle_after_alternate");
  endtask
  task automatic test_live_update();
    int n, acks;
    set_data(1, 32'hDEAD_BEEF);
    bif.src_valid = 4'b0010;
    push(4'b0010, 2'd1, 32'hDEAD_BEEF);
    wait_grant(3, n);
    repeat (3) step();
    set_data(1, 32'hCAFE_0001);
    tests++;
    if (bif.disp_value !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL live_before_edge: got %h, expected DEADBEEF", bif.disp_value);
    end
    step();
    tests++;
    if (bif.disp_value !== 32'hCAFE_0001) begin
      fails++;
      $display("FAIL live_update: got %h, expected CAFE0001", bif.disp_value);
    end
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bif.src_ack !== 4'b0) acks++;
    end
    tests++;
    if (acks !== 0) begin
      fails++;
      $display("FAIL sole_source_reack: got %0d src_ack pulses, expected 0", acks);
    end
    go_idle("idle_after_live");
  endtask
  task automatic test_lock();
    int n, bad;
    set_data(0, 32'h0A0A_0A0A);
    set_data(3, 32'h3333_3333);
    bif.src_valid = 4'b1000;
    push(4'b1000, 2'd3, 32'h3333_3333);
    wait_grant(3, n);
    bif.lock = 1'b1;
    bif.src_valid = 4'b1001;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bif.disp_src !== 2'd3 || bif.src_ack !== 4'b0) bad++;
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL lock_hold: got %0d cycles off src3 or acking, expected 0", bad);
    end
    bif.lock = 1'b0;
    push(4'b0001, 2'd0, 32'h0A0A_0A0A);
    wait_grant(9, n);
    go_idle("idle_after_lock");
  endtask
  task automatic test_early_release();
    int n;
    set_data(2, 32'h2222_2222);
    bif.src_valid = 4'b0100;
    push(4'b0100, 2'd2, 32'h2222_2222);
    wait_grant(3, n);
    repeat (2) step();
    bif.src_valid = 4'b0;
    step();
    tests++;
    if (bif.disp_blank !== 1'b0 || bif.disp_value !== 32'h2222_2222) begin
      fails++;
      $display("FAIL release_first_cycle: got blank=%b val=%h, expected 0/22222222", bif.disp_blank, bif.disp_value);
    end
    step();
    tests++;
    if (bif.disp_blank !== 1'b1 || bif.disp_value !== 32'h0) begin
      fails++;
      $display("FAIL release_idle: got blank=%b val=%h, expected 1/0", bif.disp_blank, bif.disp_value);
    end
  endtask
  task automatic test_async_reset();
    int n;
    set_data(0, 32'h0000_00AA);
    set_data(1, 32'h0000_11BB);
    bif.src_valid = 4'b0010;
    push(4'b0010, 2'd1, 32'h0000_11BB);
    wait_grant(3, n);
    repeat (2) step();
    #3 rst = 1'b0;
    #1;
    tests++;
    if (bif.disp_blank !== 1'b1 || bif.disp_value !== 32'h0 || bif.src_ack !== 4'b0 || bif.disp_src !== 2'd0) begin
      fails++;
      $display("FAIL async_reset: got blank=%b val=%h ack=%b src=%0d, expected 1/0/0/0",
               bif.disp_blank, bif.disp_value, bif.src_ack, bif.disp_src);
    end
    bif.src_valid = 4'b1111;
    step();
    tests++;
    if (bif.disp_blank !== 1'b1 || bif.src_ack !== 4'b0) begin
      fails++;
      $display("FAIL reset_held: got blank=%b ack=%b, expected 1/0", bif.disp_blank, bif.src_ack);
    end
    #2 rst = 1'b1;
    push(4'b0001, 2'd0, 32'h0000_00AA);
    push(4'b0010, 2'd1, 32'h0000_11BB);
    wait_grant(3, n);
    tests++;
    if (n !== 1) begin
      fails++;
      $display("FAIL post_reset_latency: got %0d cycles, expected 1", n);
    end
    wait_grant(10, n);
    tests++;
    if (n !== 8) begin
      fails++;
      $display("FAIL post_reset_dwell: got %0d cycles, expected 8", n);
    end
    go_idle("idle_after_reset");
  endtask
  initial begin
    test_reset();
    test_alternate();
    test_live_update();
    test_lock();
    test_early_release();
    test_async_reset();
    tests++;
    if (sb.size() !== 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending grants, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/disp_src_arbiter.md
Name: disp_src_arbiter

Overview:
- Time-multiplexes one 8-digit 7-segment display between NUM_SRC requesters, e.g. PC, instruction, register probe and bus address.
- Grants the display round-robin, holding each grant for a programmable dwell period.
- Drives the 32-bit value and blanking control into the existing scanning display driver.
- Sits between the CPU debug taps and the display driver at board top level.

Parameters:
- NUM_SRC, 4, number of requesters (2..8).
- DATA_WIDTH, 32, display value width (8 hex digits).
- DWELL_CYCLES, 50_000_000, clock cycles each grant is held (>=2); counter width = $clog2(DWELL_CYCLES).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- src_valid  in  NUM_SRC  per-source request to be displayed.
- src_data  in  NUM_SRC*DATA_WIDTH  source i value at [i*DATA_WIDTH +: DATA_WIDTH].
- lock  in  1  freeze on the current grant; suppress rotation.
- src_ack  out  NUM_SRC  one-cycle pulse on the bit of the newly granted source.
- disp_value  out  DATA_WIDTH  value to the display driver.
- disp_src  out  $clog2(NUM_SRC)  index of the granted source.
- disp_blank  out  1  1 = no source shown; driver blanks all digits.

Behaviour:
- Reset, asserted asynchronously when rst=0:
  - State IDLE, disp_value=0, disp_src=0, disp_blank=1, src_ack=0.
  - Dwell counter=0, round-robin pointer rr_last=NUM_SRC-1.
  - A reset mid-grant aborts immediately; no src_ack is produced on release.
- All outputs are registered.
- State IDLE:
  - disp_blank=1.
  - When any src_valid=1, pick the first valid index scanning from rr_last+1 with wrap-around.
  - Next cycle: state SHOW, disp_src=pick, disp_value=src_data[pick], disp_blank=0, src_ack[pick]=1 for exactly that cycle, rr_last=pick, counter=DWELL_CYCLES-1.
  - Latency from src_valid rising to grant: 1 cycle.
- State SHOW, every cycle:
  - If src_valid[disp_src]=1, disp_value reloads src_data[disp_src] (live update).
  - Otherwise disp_value holds its last value.
  - The counter decrements while nonzero.
- SHOW, counter==0 (expiry):
  - lock=1: reload counter; keep source; no src_ack.
  - lock=0 and another source valid: grant the next valid index after rr_last, excluding the current source. Same update as the IDLE grant, including a src_ack pulse.
  - lock=0, only the current source valid: reload counter; stay; no src_ack.
  - lock=0, no source valid: go to IDLE. Next cycle disp_blank=1 and disp_value=0.
- Early release: if the current source deasserts before expiry, the dwell still completes showing the held value. Exception: lock=0 with all src_valid=0 for 2 consecutive cycles returns to IDLE early.
- lock is sampled only at expiry and on the early-release check. lock=1 in IDLE has no effect.
- Simultaneous expiry and new requests: arbitration uses src_valid sampled in the expiry cycle.
- Round-robin pointer wraps from NUM_SRC-1 to 0. NUM_SRC=2 alternates strictly.
- Unused disp_src encodings are never produced.

Decomposition:
- Shared package disp_pkg:
  - State encoding constants ST_IDLE=1'b0, ST_SHOW=1'b1.
  - Source-index width function.
  - Default DWELL constant.
- One sub-module, rr_pick (combinational):
  - Inputs: request vector, rr_last.
  - Outputs: grant index and any_req.
  - Option to mask out one index, used for the expiry arbitration.
- The controller instantiates rr_pick once and feeds the mask per state.

Test Plan:
All scenarios use DWELL_CYCLES=8, NUM_SRC=4.
1. Reset, then src_valid=4'b0000 for 20 cycles -> disp_blank=1, disp_value=0, src_ack=0 throughout.
2. src_valid=4'b0101, src0=32'h1111_1111, src2=32'h2222_2222:
   - src_ack=4'b0001 one cycle after request; disp_value=32'h1111_1111.
   - After 8 cycles, src_ack=4'b0100 and disp_value=32'h2222_2222; alternation continues.
3. Only src1 valid; change src_data1 from 32'hDEAD_BEEF to 32'hCAFE_0001 mid-dwell -> disp_value follows 1 cycle later; no further src_ack after the initial grant.
4. lock=1 while src3 is granted and src0 is also valid -> disp_src stays 3 over 40 cycles. Release lock -> switch to src0 at the next expiry.
5. Granted src2 deasserts with all others idle -> IDLE after 2 cycles; disp_blank=1 on the following cycle.
6. Drive rst=0 asynchronously mid-dwell (not on a clock edge) -> outputs reach reset values before the next edge. After release with src_valid=4'b1111, the first grant is src0 (rr_last=3).
